// File: rtl/spell_mem_if.sv
// Core-request / memory-bus bundle for spell_mem_master.
// The master modport drives the bus; the slave modport is the core plus memory side.
interface spell_mem_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_write;
  logic       req_data_space;
  logic [7:0] req_addr;
  logic [7:0] req_wdata;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_error;
  logic       select;
  logic [7:0] addr;
  logic [7:0] data_in;
  logic       memory_type_data;
  logic       write;
  logic [7:0] data_out;
  logic       data_ready;

  modport master (
    input  req_valid, req_write, req_data_space, req_addr, req_wdata,
    input  data_out, data_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_error,
    output select, addr, data_in, memory_type_data, write
  );

  modport slave (
    output req_valid, req_write, req_data_space, req_addr, req_wdata,
    output data_out, data_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_error,
    input  select, addr, data_in, memory_type_data, write
  );
endinterface

// File: rtl/spell_mem_master.sv
// Single-outstanding memory bus master: takes one core request, runs one bus
// access with a timeout, and returns a one-cycle response pulse.
//
// state   | meaning
// IDLE    | req_ready high, waiting for a core request
// ACCESS  | select high, waiting for data_ready or the timeout
// RELEASE | one cycle with select low, response pulse is out
module spell_mem_master #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input logic        clk,
  input logic        rst,
  spell_mem_if.master bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RELEASE
  } state_t;

  localparam logic [7:0] LAST_WAIT = 8'(TIMEOUT_CYCLES - 1);

  state_t     state_q;
  state_t     state_d;
  logic       accept;
  logic       hit_data;
  logic       hit_timeout;

  logic [7:0] wait_cnt;
  logic       cap_write;
  logic       cap_space;
  logic [7:0] cap_addr;
  logic [7:0] cap_wdata;
  logic       rsp_valid_q;
  logic [7:0] rsp_rdata_q;
  logic       rsp_error_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    hit_data    = 1'b0;
    hit_timeout = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        // data_ready takes priority over a timeout landing in the same cycle
        if (bus.data_ready) begin
          hit_data = 1'b1;
          state_d  = RELEASE;
        end else if (wait_cnt == LAST_WAIT) begin
          hit_timeout = 1'b1;
          state_d     = RELEASE;
        end
      end
      RELEASE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt    <= 8'h00;
      cap_write   <= 1'b0;
      cap_space   <= 1'b0;
      cap_addr    <= 8'h00;
      cap_wdata   <= 8'h00;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      rsp_error_q <= 1'b0;
    end else begin
      rsp_valid_q <= hit_data | hit_timeout;
      if (accept) begin
        cap_write <= bus.req_write;
        cap_space <= bus.req_data_space;
        cap_addr  <= bus.req_addr;
        cap_wdata <= bus.req_wdata;
        wait_cnt  <= 8'h00;
      end else if (state_q == ACCESS && !bus.data_ready && wait_cnt != 8'hFF) begin
        wait_cnt <= wait_cnt + 8'h01;
      end
      if (hit_data) begin
        rsp_rdata_q <= cap_write ? 8'h00 : bus.data_out;
        rsp_error_q <= 1'b0;
      end else if (hit_timeout) begin
        rsp_rdata_q <= 8'h00;
        rsp_error_q <= 1'b1;
      end
    end
  end

  assign bus.req_ready        = (state_q == IDLE);
  assign bus.select           = (state_q == ACCESS);
  assign bus.write            = (state_q == ACCESS) && cap_write;
  assign bus.addr             = cap_addr;
  assign bus.data_in          = cap_wdata;
  assign bus.memory_type_data = cap_space;
  assign bus.rsp_valid        = rsp_valid_q;
  assign bus.rsp_rdata        = rsp_rdata_q;
  assign bus.rsp_error        = rsp_error_q;

endmodule

// File: tb/tb_spell_mem_master.sv
// Bench for spell_mem_master: directed scenarios plus random transactions,
// checked against a transaction-level model of latency, timeout and response data.
module tb_spell_mem_master;
  localparam int TO = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  int   exp_rsp_count = 0;
  int   rsp_pulses = 0;
  int   low_run = 0;
  int   last_gap = -1;

  spell_mem_if bus_if ();

  spell_mem_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  always #5 clk = ~clk;

  // Counts response pulses and the length of select-low runs between accesses.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_if.rsp_valid) rsp_pulses++;
      if (bus_if.select) begin
        if (low_run > 0) last_gap = low_run;
        low_run = 0;
      end else begin
        low_run++;
      end
    end
  end

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entry and exit are at a falling edge. dly = ACCESS cycle in which the
  // responder raises data_ready; dly > TO means the responder never answers.
  task automatic run_txn(input bit w, input bit sp, input logic [7:0] a, input logic [7:0] wd,
                         input logic [7:0] rd, input int dly, input bit hold);
    bit         exp_err = (dly > TO);
    int         exp_sel = exp_err ? TO : dly;
    logic [7:0] exp_rd  = (w || exp_err) ? 8'h00 : rd;
    int         sel     = 0;
    bit         done    = 1'b0;
    for (int i = 0; i < 20 && !bus_if.req_ready; i++) @(negedge clk);
    chk(bus_if.req_ready, 1, "req_ready_idle");
    bus_if.req_valid      = 1'b1;
    bus_if.req_write      = w;
    bus_if.req_data_space = sp;
    bus_if.req_addr       = a;
    bus_if.req_wdata      = wd;
    exp_rsp_count++;
    @(negedge clk);
    if (!hold) begin
      bus_if.req_valid      = 1'b0;
      bus_if.req_write      = 1'($urandom);
      bus_if.req_data_space = 1'($urandom);
      bus_if.req_addr       = 8'($urandom);
      bus_if.req_wdata      = 8'($urandom);
    end
    for (int i = 0; i < 300 && !done; i++) begin
      if (bus_if.select) begin
        sel++;
        chk(bus_if.addr, a, "acc_addr");
        chk(bus_if.data_in, wd, "acc_data_in");
        chk(bus_if.memory_type_data, sp, "acc_space");
        chk(bus_if.write, w, "acc_write");
        chk(bus_if.rsp_valid, 0, "acc_no_rsp");
        chk(bus_if.req_ready, 0, "acc_not_ready");
        bus_if.data_ready = (sel == dly);
        bus_if.data_out   = (sel == dly) ? rd : 8'($urandom);
        @(negedge clk);
      end else begin
        bus_if.data_ready = 1'b0;
        done = 1'b1;
        chk(bus_if.rsp_valid, 1, "rsp_pulse");
        chk(bus_if.rsp_error, exp_err, "rsp_error");
        chk(bus_if.rsp_rdata, exp_rd, "rsp_rdata");
        chk(sel, exp_sel, "select_cycles");
        chk(bus_if.req_ready, 0, "release_not_ready");
        chk(bus_if.write, 0, "release_write");
        chk(bus_if.addr, a, "release_addr_hold");
        @(negedge clk);
        chk(bus_if.rsp_valid, 0, "rsp_single_cycle");
        chk(bus_if.rsp_rdata, exp_rd, "rsp_rdata_hold");
        chk(bus_if.rsp_error, exp_err, "rsp_error_hold");
        chk(bus_if.select, 0, "idle_select");
        chk(bus_if.req_ready, 1, "idle_ready");
      end
    end
    chk(done, 1, "rsp_within_bound");
  endtask

  initial begin
    bus_if.req_valid      = 1'b1;
    bus_if.req_write      = 1'b1;
    bus_if.req_data_space = 1'b1;
    bus_if.req_addr       = 8'h5A;
    bus_if.req_wdata      = 8'hC3;
    bus_if.data_out       = 8'h00;
    bus_if.data_ready     = 1'b0;

    // reset values appear without a clock edge
    #2;
    chk(bus_if.select, 0, "rst_select");
    chk(bus_if.write, 0, "rst_write");
    chk(bus_if.rsp_valid, 0, "rst_rsp_valid");
    chk(bus_if.rsp_error, 0, "rst_rsp_error");
    chk(bus_if.rsp_rdata, 0, "rst_rsp_rdata");
    chk(bus_if.addr, 0, "rst_addr");
    chk(bus_if.data_in, 0, "rst_data_in");
    chk(bus_if.memory_type_data, 0, "rst_space");

    // requests presented during reset are not accepted
    repeat (3) @(negedge clk);
    chk(bus_if.select, 0, "rst_no_accept");
    chk(bus_if.req_ready, 1, "rst_ready");
    chk(bus_if.addr, 0, "rst_no_capture");
    bus_if.req_valid = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // data_ready while idle is ignored
    bus_if.data_ready = 1'b1;
    bus_if.data_out   = 8'hEE;
    repeat (3) begin
      @(negedge clk);
      chk(bus_if.rsp_valid, 0, "idle_dr_no_rsp");
      chk(bus_if.select, 0, "idle_dr_select");
      chk(bus_if.req_ready, 1, "idle_dr_ready");
    end
    bus_if.data_ready = 1'b0;

    run_txn(1'b0, 1'b1, 8'h10, 8'h00, 8'hA5, 3, 1'b0);      // load, 3-cycle access
    run_txn(1'b1, 1'b1, 8'h25, 8'h3C, 8'h99, 2, 1'b0);      // store
    run_txn(1'b0, 1'b1, 8'h40, 8'h00, 8'h12, 100, 1'b0);    // timeout
    run_txn(1'b0, 1'b0, 8'h41, 8'h00, 8'h77, TO, 1'b0);     // data_ready on the last wait cycle
    run_txn(1'b0, 1'b1, 8'h42, 8'h00, 8'h5E, 1, 1'b0);      // minimum latency

    // back-to-back code-space loads with req_valid held; the gap is the
    // RELEASE cycle plus the IDLE cycle in which the next request is accepted
    run_txn(1'b0, 1'b0, 8'h80, 8'h00, 8'h11, 2, 1'b1);
    run_txn(1'b0, 1'b0, 8'h81, 8'h00, 8'h22, 1, 1'b0);
    chk(last_gap, 2, "b2b_select_gap");

    // reset mid-access aborts silently
    bus_if.req_valid      = 1'b1;
    bus_if.req_write      = 1'b0;
    bus_if.req_data_space = 1'b1;
    bus_if.req_addr       = 8'h66;
    @(negedge clk);
    bus_if.req_valid = 1'b0;
    chk(bus_if.select, 1, "pre_rst_select");
    #1 rst = 1'b1;
    #1;
    chk(bus_if.select, 0, "rst_async_select");
    chk(bus_if.rsp_valid, 0, "rst_async_rsp");
    chk(bus_if.req_ready, 1, "rst_async_ready");
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk(bus_if.rsp_valid, 0, "post_rst_no_rsp");
      chk(bus_if.req_ready, 1, "post_rst_ready");
    end
    run_txn(1'b1, 1'b0, 8'h67, 8'hD2, 8'h00, 2, 1'b0);

    // random traffic across fast, slow, boundary and timed-out responses
    for (int t = 0; t < 24; t++) begin
      run_txn(1'($urandom), 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
              int'($urandom_range(1, TO + 2)), 1'b0);
    end

    chk(rsp_pulses, exp_rsp_count, "rsp_pulse_count");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
